// File: rtl/blob_frame_gen_pkg.sv
// Shared types and constants for the synthetic binary-frame source.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package blob_frame_gen_pkg;

   localparam int COORD_W   = 16;
   localparam int NUM_BLOBS = 4;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_HBLANK = 2'd2,
      ST_VBLANK = 2'd3
   } state_t;

endpackage

// File: rtl/blob_frame_gen_hit.sv
// Square-blob membership test for one blob at one pixel coordinate.
// Latency: purely combinational.
// Backpressure: none; result follows the inputs.
module blob_hit
   import blob_frame_gen_pkg::*;
(
   input  logic [COORD_W-1:0] h,
   input  logic [COORD_W-1:0] v,
   input  logic [COORD_W-1:0] ctr_h,
   input  logic [COORD_W-1:0] ctr_v,
   input  logic [7:0]         r,
   input  logic               en,
   output logic               hit
);

   logic signed [COORD_W:0] dh;
   logic signed [COORD_W:0] dv;
   logic        [COORD_W:0] mag_h;
   logic        [COORD_W:0] mag_v;
   logic        [COORD_W:0] r_ext;

   // Differences use one extra sign bit so coordinates near 0 or 65535 never wrap.
   always_comb begin
      dh    = $signed({1'b0, h}) - $signed({1'b0, ctr_h});
      dv    = $signed({1'b0, v}) - $signed({1'b0, ctr_v});
      mag_h = dh[COORD_W] ? $unsigned(-dh) : $unsigned(dh);
      mag_v = dv[COORD_W] ? $unsigned(-dv) : $unsigned(dv);
      r_ext = {{(COORD_W + 1 - 8){1'b0}}, r};
      hit   = en && (mag_h <= r_ext) && (mag_v <= r_ext);
   end

endmodule

// File: rtl/blob_frame_gen.sv
// Synthetic VGA-like binary frame source with up to four square blobs.
// Latency: all outputs registered; mask, coordinates and strobes are coherent per cycle.
// Backpressure: none; free-running while EN is high, EN only sampled at frame boundaries.
module blob_frame_gen
   import blob_frame_gen_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 160,
   parameter int V_ACTIVE = 480,
   parameter int V_BLANK  = 800
)
(
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               EN,
   input  logic [NUM_BLOBS-1:0] BLOB_EN,
   input  logic [COORD_W-1:0] BLOB_H_0,
   input  logic [COORD_W-1:0] BLOB_H_1,
   input  logic [COORD_W-1:0] BLOB_H_2,
   input  logic [COORD_W-1:0] BLOB_H_3,
   input  logic [COORD_W-1:0] BLOB_V_0,
   input  logic [COORD_W-1:0] BLOB_V_1,
   input  logic [COORD_W-1:0] BLOB_V_2,
   input  logic [COORD_W-1:0] BLOB_V_3,
   input  logic [7:0]         BLOB_R,
   output logic               VGA_HS,
   output logic               VGA_VS,
   output logic [COORD_W-1:0] H_CNT,
   output logic [COORD_W-1:0] V_CNT,
   output logic               BINARY_FLAG,
   output logic               FRAME_DONE
);

   if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_BLANK < 1 || V_BLANK < 1) begin : g_bad_params
      $error("blob_frame_gen: H_ACTIVE, V_ACTIVE, H_BLANK and V_BLANK must all be >= 1");
   end

   localparam coord_t H_LAST  = coord_t'(H_ACTIVE - 1);
   localparam coord_t V_LAST  = coord_t'(V_ACTIVE - 1);
   localparam coord_t HB_LAST = coord_t'(H_BLANK - 1);
   localparam coord_t VB_LAST = coord_t'(V_BLANK - 1);
   localparam coord_t ONE     = coord_t'(1);

   state_t state;
   state_t nxt_state;
   coord_t h, v, bcnt;
   coord_t nxt_h, nxt_v, nxt_bcnt;
   logic   load;

   // Config shadow, captured when a frame's first ACTIVE cycle is entered.
   logic [NUM_BLOBS-1:0] sh_en;
   coord_t               sh_h [NUM_BLOBS];
   coord_t               sh_v [NUM_BLOBS];
   logic [7:0]           sh_r;

   coord_t               in_h [NUM_BLOBS];
   coord_t               in_v [NUM_BLOBS];
   logic [NUM_BLOBS-1:0] mk_en;
   coord_t               mk_h [NUM_BLOBS];
   coord_t               mk_v [NUM_BLOBS];
   logic [7:0]           mk_r;
   logic [NUM_BLOBS-1:0] hits;

   assign in_h[0] = BLOB_H_0;
   assign in_h[1] = BLOB_H_1;
   assign in_h[2] = BLOB_H_2;
   assign in_h[3] = BLOB_H_3;
   assign in_v[0] = BLOB_V_0;
   assign in_v[1] = BLOB_V_1;
   assign in_v[2] = BLOB_V_2;
   assign in_v[3] = BLOB_V_3;

   // Next-state and next-coordinate decode; outputs are registered from these
   // so the mask lines up with the coordinate it is computed for.
   always_comb begin
      nxt_state = state;
      nxt_h     = h;
      nxt_v     = v;
      nxt_bcnt  = bcnt;
      load      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (EN) begin
               nxt_state = ST_ACTIVE;
               nxt_h     = '0;
               nxt_v     = '0;
               load      = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (h == H_LAST) begin
               nxt_state = ST_HBLANK;
               nxt_bcnt  = '0;
            end else begin
               nxt_h = h + ONE;
            end
         end
         ST_HBLANK: begin
            if (bcnt == HB_LAST) begin
               nxt_h = '0;
               if (v == V_LAST) begin
                  // Coordinates read 0 throughout vertical blanking.
                  nxt_state = ST_VBLANK;
                  nxt_v     = '0;
                  nxt_bcnt  = '0;
               end else begin
                  nxt_state = ST_ACTIVE;
                  nxt_v     = v + ONE;
               end
            end else begin
               nxt_bcnt = bcnt + ONE;
            end
         end
         ST_VBLANK: begin
            if (bcnt == VB_LAST) begin
               nxt_h = '0;
               nxt_v = '0;
               if (EN) begin
                  nxt_state = ST_ACTIVE;
                  load      = 1'b1;
               end else begin
                  nxt_state = ST_IDLE;
               end
            end else begin
               nxt_bcnt = bcnt + ONE;
            end
         end
         default: begin
            nxt_state = ST_IDLE;
            nxt_h     = '0;
            nxt_v     = '0;
            nxt_bcnt  = '0;
         end
      endcase
   end

   // Blob parameters seen by the mask: the live inputs on the cycle they are captured.
   always_comb begin
      mk_en = load ? BLOB_EN : sh_en;
      mk_r  = load ? BLOB_R  : sh_r;
      for (int i = 0; i < NUM_BLOBS; i++) begin
         mk_h[i] = load ? in_h[i] : sh_h[i];
         mk_v[i] = load ? in_v[i] : sh_v[i];
      end
   end

   for (genvar gi = 0; gi < NUM_BLOBS; gi++) begin : g_hit
      blob_hit u_hit (
         .h     (nxt_h),
         .v     (nxt_v),
         .ctr_h (mk_h[gi]),
         .ctr_v (mk_v[gi]),
         .r     (mk_r),
         .en    (mk_en[gi]),
         .hit   (hits[gi])
      );
   end

   // FSM state, counters, config shadow and all registered outputs.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state       <= ST_IDLE;
         h           <= '0;
         v           <= '0;
         bcnt        <= '0;
         sh_en       <= '0;
         sh_r        <= '0;
         for (int i = 0; i < NUM_BLOBS; i++) begin
            sh_h[i] <= '0;
            sh_v[i] <= '0;
         end
         VGA_HS      <= 1'b0;
         VGA_VS      <= 1'b0;
         H_CNT       <= '0;
         V_CNT       <= '0;
         BINARY_FLAG <= 1'b0;
         FRAME_DONE  <= 1'b0;
      end else begin
         state <= nxt_state;
         h     <= nxt_h;
         v     <= nxt_v;
         bcnt  <= nxt_bcnt;
         if (load) begin
            sh_en <= BLOB_EN;
            sh_r  <= BLOB_R;
            for (int i = 0; i < NUM_BLOBS; i++) begin
               sh_h[i] <= in_h[i];
               sh_v[i] <= in_v[i];
            end
         end
         VGA_HS      <= (nxt_state == ST_ACTIVE);
         VGA_VS      <= (nxt_state == ST_ACTIVE) || (nxt_state == ST_HBLANK);
         H_CNT       <= nxt_h;
         V_CNT       <= nxt_v;
         BINARY_FLAG <= (nxt_state == ST_ACTIVE) && (|hits);
         FRAME_DONE  <= (nxt_state == ST_VBLANK) && (nxt_bcnt == VB_LAST);
      end
   end

endmodule

// File: doc/blob_frame_gen.md
Name: blob_frame_gen

Overview:
- Synthetic binary-frame source for the marker-detection path.
- Generates active-high line/frame strobes (VGA_HS, VGA_VS), pixel coordinates (H_CNT, V_CNT) and a BINARY_FLAG mask containing up to 4 programmable square blobs.
- Drives the same interface the multi-point finder consumes, so that finder can be exercised in simulation and on board without the D8M camera.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_BLANK, 160, blanking cycles after each line (HS=0)
- V_ACTIVE, 480, active lines per frame
- V_BLANK, 800, blanking cycles after the last line of a frame (VS=0)

Ports:
- CLK  in  1  pixel clock
- RST_N  in  1  synchronous active-low reset
- EN  in  1  run enable; sampled at frame boundaries
- BLOB_EN  in  4  per-blob enable
- BLOB_H_0..BLOB_H_3  in  16  blob centre column
- BLOB_V_0..BLOB_V_3  in  16  blob centre row
- BLOB_R  in  8  half-size shared by all blobs
- VGA_HS  out  1  high while the current line is emitting active pixels
- VGA_VS  out  1  high during the active lines of a frame
- H_CNT  out  16  pixel column, 0..H_ACTIVE-1
- V_CNT  out  16  pixel row, 0..V_ACTIVE-1
- BINARY_FLAG  out  1  mask bit for (H_CNT, V_CNT)
- FRAME_DONE  out  1  one-cycle pulse at the end of vertical blanking

Behaviour:
- Clock and reset: single clock CLK. Reset is synchronous, active-low on RST_N.
- Reset values: all outputs 0; FSM in IDLE; internal counters 0.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE:
  - All outputs 0.
  - If EN=1, the config shadow is loaded and the FSM enters ACTIVE with h=0, v=0.
- ACTIVE:
  - VGA_VS=1, VGA_HS=1, H_CNT=h, V_CNT=v, BINARY_FLAG=mask(h,v).
  - h increments each cycle.
  - At h=H_ACTIVE-1 the FSM goes to HBLANK.
- HBLANK:
  - VGA_VS=1, VGA_HS=0, BINARY_FLAG=0. H_CNT and V_CNT hold their last values.
  - Lasts H_BLANK cycles. After that, v increments and h=0.
  - If the line just finished was v=V_ACTIVE-1, the FSM goes to VBLANK; otherwise it returns to ACTIVE.
- VBLANK:
  - VGA_VS=0, VGA_HS=0, BINARY_FLAG=0.
  - Lasts V_BLANK cycles. On the last cycle FRAME_DONE=1.
  - Next state: if EN=1, reload the shadow and go to ACTIVE; if EN=0, go to IDLE.
- Output timing: all outputs are registered. H_CNT, V_CNT, BINARY_FLAG, VGA_HS and VGA_VS are mutually coherent in the same cycle; the mask is not offset by one pixel.
- Mask rule: pixel is 1 iff, for some i with BLOB_EN[i]=1, |h - BLOB_H_i| <= BLOB_R and |v - BLOB_V_i| <= BLOB_R.
  - Differences are computed in 17-bit signed arithmetic, so there is no wrap near coordinate 0 or 65535.
  - Blobs extending past frame edges are clipped by the counter range.
  - Overlapping blobs are ORed together.
  - BLOB_R=0 gives a single pixel.
- Config shadow: BLOB_* values are captured only on entry to the frame's first ACTIVE cycle. Changes mid-frame take effect the following frame.
- EN deasserted mid-frame: the current frame completes, including VBLANK and FRAME_DONE, then the FSM enters IDLE.
- Reset mid-frame (RST_N=0 in any state): all outputs are 0 at the next edge and the FSM is in IDLE.
- Minimum parameter values: H_BLANK >= 1 and V_BLANK >= 1. Values of 0 are illegal; an elaboration-time check rejects them.

Decomposition:
- Shared package:
  - FSM state encoding (2-bit: IDLE, ACTIVE, HBLANK, VBLANK)
  - 16-bit coordinate width constant
  - NUM_BLOBS=4 constant
- Sub-module blob_hit: purely combinational.
  - Inputs: h, v, centre H/V, R, enable.
  - Output: 1-bit hit.
  - Instantiated 4 times; the top level ORs the hits and registers the result.

Test Plan (bench params: H_ACTIVE=10, H_BLANK=1, V_ACTIVE=10, V_BLANK=1, matching the 10x10 finder bench):
- Run with all blobs disabled (EN=1, BLOB_EN=0) for one frame -> 100 ACTIVE cycles with HS=1, BINARY_FLAG always 0, exactly one FRAME_DONE pulse; the next frame starts 1 cycle after VBLANK.
- Blob 0 at (4,5) with R=1 -> BINARY_FLAG=1 for exactly 9 pixels, h in 3..5 and v in 4..6. Feeding the output to the multi-point finder reports POINTS_NUM=1 with the point at (4,5).
- Four blobs at (1,1), (8,1), (1,8), (8,8) with R=0 -> exactly 4 set pixels at those coordinates; the finder reports POINTS_NUM=4.
- Blob at (0,0) with R=3 -> 16 set pixels (h and v in 0..3) and no set pixels near 65535; this checks the signed-difference rule.
- Change BLOB_H_0 from 4 to 7 while v=3 -> current frame still shows the blob centred at h=4; the next frame shows it centred at h=7.
- Drop EN at v=5 -> frame finishes and FRAME_DONE pulses, then the block sits in IDLE with outputs 0. Then assert RST_N=0 while in ACTIVE at v=2 -> next cycle all outputs are 0 and the state is IDLE.
